// File: rtl/prescaled_digit_counter_if.sv
// Control and status bundle for prescaled_digit_counter.
// The counter takes the slave side; the driving logic takes the master side.
interface prescaled_digit_counter_if #(
   parameter int DIGITS = 2
);
   logic                  ena;
   logic [7:0]            cmp;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count;
   logic                  tick;
   logic                  wrap;

   modport master (
      output ena,
      output cmp,
      output up,
      output load,
      output load_val,
      input  count,
      input  tick,
      input  wrap
   );

   modport slave (
      input  ena,
      input  cmp,
      input  up,
      input  load,
      input  load_val,
      output count,
      output tick,
      output wrap
   );
endinterface

// File: rtl/prescaled_digit_counter.sv
// Programmable prescaler driving a chain of radix-MODULUS up/down digits.
// Load, step tick and chain wrap are all registered on the same edge.
module prescaled_digit_counter #(
   parameter int DIGITS     = 2,
   parameter int MODULUS    = 10,
   parameter int PRESCALE_W = 24,
   parameter int CMP_SHIFT  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prescaled_digit_counter_if.slave bus
);

   localparam int         CW    = 4 * DIGITS;
   localparam logic [3:0] D_MAX = 4'(MODULUS - 1);

   logic [PRESCALE_W-1:0] prescaler;
   logic [PRESCALE_W-1:0] compare;
   logic                  match;

   logic [CW-1:0]         count_q;
   logic                  tick_q;
   logic                  wrap_q;

   logic [CW-1:0]         step_count;
   logic                  step_out;
   logic [CW-1:0]         load_count;

   always_comb begin
      compare = PRESCALE_W'(bus.cmp) << CMP_SHIFT;
      match   = (prescaler >= compare);
   end

   // Carry/borrow ripples from digit 0 upward within one edge.
   always_comb begin
      logic       c;
      logic [3:0] d;
      step_count = count_q;
      c          = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = count_q[4*i +: 4];
         if (c) begin
            if (bus.up) begin
               if (d >= D_MAX) begin
                  step_count[4*i +: 4] = 4'd0;
                  c                    = 1'b1;
               end else begin
                  step_count[4*i +: 4] = d + 4'd1;
                  c                    = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  step_count[4*i +: 4] = D_MAX;
                  c                    = 1'b1;
               end else begin
                  step_count[4*i +: 4] = d - 4'd1;
                  c                    = 1'b0;
               end
            end
         end
      end
      step_out = c;
   end

   // Out-of-range load fields saturate so no digit can reach MODULUS.
   always_comb begin
      logic [3:0] f;
      load_count = '0;
      for (int i = 0; i < DIGITS; i++) begin
         f = bus.load_val[4*i +: 4];
         load_count[4*i +: 4] = (f > D_MAX) ? D_MAX : f;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         count_q   <= '0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else if (bus.load) begin
         prescaler <= '0;
         count_q   <= load_count;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else if (bus.ena) begin
         if (match) begin
            prescaler <= '0;
            count_q   <= step_count;
            tick_q    <= 1'b1;
            wrap_q    <= step_out;
         end else begin
            prescaler <= prescaler + 1'b1;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end
   end

   assign bus.count = count_q;
   assign bus.tick  = tick_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: doc/prescaled_digit_counter.md
# prescaled_digit_counter

Parametrised successor to the single-digit seconds counter in the top-level demo. A programmable prescaler divides `clk` down to a step tick, and that tick drives a chain of DIGITS radix-MODULUS digit counters. The counters can count up or down, load a value synchronously, and report a wrap of the whole chain. It sits between the top-level pin wrapper (`cmp` from `ui_in`) and the display/node logic, replacing the hard-wired 0–9 counter.

## Interface

- DIGITS, 2, number of chained digits (1..4)
- MODULUS, 10, radix of every digit (2..16); each digit spans 0..MODULUS-1 in a 4-bit field
- PRESCALE_W, 24, prescaler width; must be >= CMP_SHIFT+8
- CMP_SHIFT, 10, left shift applied to `cmp` to form the compare value

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous and active-low
- ena  in  1  count enable; low freezes prescaler and digits
- cmp  in  8  prescale select; compare = zero-extended {cmp, CMP_SHIFT'b0}
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  load value; digit i is in bits [4i+3:4i]
- count  out  4*DIGITS  current digits, digit 0 in the LSBs, registered
- tick  out  1  one-cycle pulse when the digits step
- wrap  out  1  one-cycle pulse when the chain wraps (carry/borrow out of the top digit)

## Operation

- Reset (rst_n low, asynchronous): prescaler=0, count=0, tick=0, wrap=0.
- Priority per rising edge: load > (ena and match) > (ena, no match) > hold.
- Match condition: prescaler >= compare. Using >= rather than == means that lowering `cmp` below the current prescaler value matches on the next enabled edge. There is no 2^PRESCALE_W wait.
- On match:
  - prescaler <= 0 and tick <= 1.
  - The digits step once.
- Without a match (ena=1):
  - prescaler <= prescaler+1 and tick <= 0.
- When ena=0:
  - prescaler and count hold.
  - tick and wrap are driven to 0.
- Step, up=1:
  - Digit 0 increments.
  - A digit at MODULUS-1 goes to 0 and carries into the next digit.
  - The carry ripples combinationally within the same edge.
- Step, up=0:
  - Digit 0 decrements.
  - A digit at 0 goes to MODULUS-1 and borrows from the next digit.
- wrap <= 1 on a step that produces a carry or borrow out of digit DIGITS-1. Examples with DIGITS=2, MODULUS=10: 99->00 counting up, 00->99 counting down. Otherwise wrap <= 0.
- Load:
  - Each digit is loaded from load_val; any field >= MODULUS is clamped to MODULUS-1.
  - prescaler <= 0, tick <= 0, wrap <= 0.
  - Load is honoured even when ena=0.
  - A match in the same cycle is discarded: no step and no tick.
- Changing `up`, `cmp` or `ena` mid-interval has no effect other than on subsequent edges. The prescaler value is not reset by a cmp change.
- Invariant: every digit is always < MODULUS. No out-of-range state is reachable.

## Timing

- Step period = compare+1 enabled cycles. cmp=0 gives a step every enabled cycle.
- The count, tick and wrap updates share the same edge, so tick/wrap are high during the first cycle that shows the new count.
- Latency from load sampled to count updated: 1 cycle.
- First tick after reset release with ena=1 held: on edge number compare+1 (prescaler counts 0..compare).
- Asserting rst_n low at any point, including the cycle of a tick or load, clears all state immediately. Nothing from that cycle survives.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Defaults, cmp=0, up=1, ena=1 after reset: count steps 0x00,0x01,…,0x09,0x10,…,0x99,0x00 on consecutive cycles. tick is high every cycle after the first. wrap is high only in the cycle showing 0x00 after 0x99.
- cmp=1 (compare=1024), up=1: first tick 1025 cycles after ena rises, then every 1025 cycles. count=0x01 at the first tick, 0x02 at the second.
- up=0 from reset, cmp=0: count goes 0x00→0x99 with wrap=1 on that step, then 0x98, 0x97.
- load=1, load_val=0x5C while a match is due: count=0x59 next cycle (digit 0 clamped), tick=0, wrap=0, prescaler restarts at 0.
- Lowering cmp: with cmp=4 and prescaler at ~3000, change cmp to 1 → tick on the next enabled edge. Then drop ena for 50 cycles → count frozen and tick=0 throughout.
- Pull rst_n low asynchronously mid-interval while count=0x37 → count=0x00 and tick=wrap=0 before the next clk edge. Counting resumes from a prescaler of 0 after release.
